// File: rtl/pattern_scan_ctrl.sv
// Word-to-serial sequencer for the 2-of-3 pattern detector: shifts each accepted word
// MSB-first into the detector and returns hit count / first hit index per word.
module pattern_scan_ctrl #(
  parameter int unsigned WORD_W = 16
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      abort,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W-1:0]         in_data,
  output logic                      det_enable,
  output logic                      det_serial,
  input  logic                      det_hit,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(WORD_W)-1:0] res_count,
  output logic                      res_any,
  output logic [$clog2(WORD_W)-1:0] res_first_idx
);

  localparam int unsigned IDX_W = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] sreg, sreg_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [IDX_W-1:0]  prev_idx;
  logic              qual, qual_nxt;
  logic [IDX_W-1:0]  count_nxt, first_nxt;
  logic              any_nxt;
  logic              in_ready_nxt, det_enable_nxt, det_serial_nxt, res_valid_nxt;

  // Next-state, result accumulation and registered-output next values
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    idx_nxt   = idx;
    count_nxt = res_count;
    any_nxt   = res_any;
    first_nxt = res_first_idx;

    // qual/prev_idx line det_hit up with the bit that produced it one cycle earlier
    if (qual && det_hit) begin
      count_nxt = res_count + IDX_W'(1);
      if (!res_any) begin
        any_nxt   = 1'b1;
        first_nxt = prev_idx;
      end
    end

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_nxt = SHIFT;
          sreg_nxt  = in_data;
          idx_nxt   = '0;
          count_nxt = '0;
          any_nxt   = 1'b0;
          first_nxt = '0;
        end
      end
      SHIFT: begin
        sreg_nxt = sreg << 1;
        idx_nxt  = idx + IDX_W'(1);
        if (idx == IDX_LAST) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (abort) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      count_nxt = '0;
      any_nxt   = 1'b0;
      first_nxt = '0;
    end

    qual_nxt       = (state == SHIFT) && !abort;
    in_ready_nxt   = (state_nxt == IDLE);
    det_enable_nxt = (state_nxt == SHIFT);
    det_serial_nxt = (state_nxt == SHIFT) ? sreg_nxt[WORD_W-1] : 1'b0;
    res_valid_nxt  = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state         <= IDLE;
      sreg          <= '0;
      idx           <= '0;
      prev_idx      <= '0;
      qual          <= 1'b0;
      in_ready      <= 1'b0;
      det_enable    <= 1'b0;
      det_serial    <= 1'b0;
      res_valid     <= 1'b0;
      res_count     <= '0;
      res_any       <= 1'b0;
      res_first_idx <= '0;
    end else begin
      state         <= state_nxt;
      sreg          <= sreg_nxt;
      idx           <= idx_nxt;
      prev_idx      <= idx;
      qual          <= qual_nxt;
      in_ready      <= in_ready_nxt;
      det_enable    <= det_enable_nxt;
      det_serial    <= det_serial_nxt;
      res_valid     <= res_valid_nxt;
      res_count     <= count_nxt;
      res_any       <= any_nxt;
      res_first_idx <= first_nxt;
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl with a behavioural exactly-2-of-3 serial detector.
module tb_pattern_scan_ctrl;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned IDX_W  = $clog2(WORD_W);

  logic              clk = 1'b0;
  logic              rstb, abort, in_valid, in_ready;
  logic [WORD_W-1:0] in_data;
  logic              det_enable, det_serial, det_hit;
  logic              res_valid, res_ready, res_any;
  logic [IDX_W-1:0]  res_count, res_first_idx;

  int checks   = 0;
  int failures = 0;

  pattern_scan_ctrl #(.WORD_W(WORD_W)) dut (
    .clk(clk), .rstb(rstb), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .det_enable(det_enable), .det_serial(det_serial), .det_hit(det_hit),
    .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
    .res_any(res_any), .res_first_idx(res_first_idx)
  );

  always #5 clk = ~clk;

  // Detector: registered hit when exactly two of the last three enabled bits are 1
  logic [1:0] dhist;
  logic [1:0] dfill;
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      dhist <= '0; dfill <= '0; det_hit <= 1'b0;
    end else if (!det_enable) begin
      dhist <= '0; dfill <= '0; det_hit <= 1'b0;
    end else begin
      dhist   <= {dhist[0], det_serial};
      if (dfill != 2'd2) dfill <= dfill + 2'd1;
      det_hit <= (dfill == 2'd2) && ($countones({dhist, det_serial}) == 2);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word, wait for its acceptance edge, then count edges until res_valid
  task automatic start_and_wait(input logic [WORD_W-1:0] data, output int lat);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = data;
    while (!in_ready && n < 50) begin tick(); n++; end
    check_eq("accept_wait", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_data  = ~data;
    lat = 0;
    while (!res_valid && lat < 100) begin tick(); lat++; end
  endtask

  task automatic scan(input logic [WORD_W-1:0] data, output int lat,
                      output logic [63:0] cnt, output logic [63:0] any, output logic [63:0] first);
    start_and_wait(data, lat);
    cnt   = 64'(res_count);
    any   = 64'(res_any);
    first = 64'(res_first_idx);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nacc, nres, gap;
    logic en_seen, gap_done, rv_seen;
    int acc_cyc [2];
    logic [63:0] r_cnt [2];
    logic [63:0] r_any [2];
    logic [63:0] c, a, f;

    rstb = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    tick();
    check_eq("rst_in_ready",   64'(in_ready), 64'd0);
    check_eq("rst_det_enable", 64'(det_enable), 64'd0);
    check_eq("rst_det_serial", 64'(det_serial), 64'd0);
    check_eq("rst_res_valid",  64'(res_valid), 64'd0);
    check_eq("rst_res_count",  64'(res_count), 64'd0);
    check_eq("rst_res_any",    64'(res_any), 64'd0);
    check_eq("rst_first_idx",  64'(res_first_idx), 64'd0);
    rstb = 1'b1;
    tick();
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

    // 0110_0000...: windows 011 and 110 hit at idx 2,3; DONE follows the accept edge by WORD_W+1 edges
    scan(16'h6000, lat, c, a, f);
    check_eq("w6000_latency", 64'(lat), 64'(WORD_W + 1));
    check_eq("w6000_count", c, 64'd2);
    check_eq("w6000_any",   a, 64'd1);
    check_eq("w6000_first", f, 64'd2);

    scan(16'hAAAA, lat, c, a, f);
    check_eq("wAAAA_count", c, 64'd7);
    check_eq("wAAAA_first", f, 64'd2);
    scan(16'h5555, lat, c, a, f);
    check_eq("w5555_count", c, 64'd7);
    check_eq("w5555_any",   a, 64'd1);
    check_eq("w5555_first", f, 64'd3);

    scan(16'hFFFF, lat, c, a, f);
    check_eq("wFFFF_count", c, 64'd0);
    check_eq("wFFFF_any",   a, 64'd0);
    check_eq("wFFFF_first", f, 64'd0);
    scan(16'h0000, lat, c, a, f);
    check_eq("w0000_count", c, 64'd0);
    check_eq("w0000_any",   a, 64'd0);
    check_eq("w0000_first", f, 64'd0);

    // Back-to-back words with res_ready tied high
    res_ready = 1'b1; in_valid = 1'b1; in_data = 16'h6000;
    nacc = 0; nres = 0; gap = 0; en_seen = 1'b0; gap_done = 1'b0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    r_cnt[0] = '1; r_cnt[1] = '1; r_any[0] = '1; r_any[1] = '1;
    for (int cyc = 0; cyc < 80 && nres < 2; cyc++) begin
      if (det_enable) begin
        if (gap > 0) gap_done = 1'b1;
        en_seen = 1'b1;
      end else if (en_seen && !gap_done) begin
        gap++;
      end
      if (in_valid && in_ready && nacc < 2) begin acc_cyc[nacc] = cyc; nacc++; end
      if (res_valid && res_ready) begin
        r_cnt[nres] = 64'(res_count);
        r_any[nres] = 64'(res_any);
        nres++;
      end
      tick();
      if (nacc == 1) in_data = 16'hFFFF;
      else if (nacc == 2) in_valid = 1'b0;
    end
    res_ready = 1'b0; in_valid = 1'b0;
    check_eq("b2b_results", 64'(nres), 64'd2);
    check_eq("b2b_first_count", r_cnt[0], 64'd2);
    check_eq("b2b_second_count", r_cnt[1], 64'd0);
    check_eq("b2b_second_any", r_any[1], 64'd0);
    check_eq("b2b_enable_gap", 64'(gap), 64'd3);
    check_eq("b2b_period", 64'(acc_cyc[1] - acc_cyc[0]), 64'(WORD_W + 3));

    // Result held while res_ready is low; in_valid during DONE is not taken
    start_and_wait(16'hAAAA, lat);
    in_valid = 1'b1; in_data = 16'h6000;
    for (int i = 0; i < 10; i++) begin
      check_eq("hold_res_valid", 64'(res_valid), 64'd1);
      check_eq("hold_in_ready",  64'(in_ready), 64'd0);
      check_eq("hold_count",     64'(res_count), 64'd7);
      check_eq("hold_first",     64'(res_first_idx), 64'd2);
      check_eq("hold_det_enable", 64'(det_enable), 64'd0);
      tick();
    end
    in_valid = 1'b0; res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq("hold_release_valid", 64'(res_valid), 64'd0);
    tick();
    check_eq("hold_idle_ready", 64'(in_ready), 64'd1);
    check_eq("hold_idle_enable", 64'(det_enable), 64'd0);

    // Abort at SHIFT idx 5
    in_valid = 1'b1; in_data = 16'hAAAA;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check_eq("abort_pre_enable", 64'(det_enable), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_enable",   64'(det_enable), 64'd0);
    check_eq("abort_in_ready", 64'(in_ready), 64'd1);
    check_eq("abort_valid",    64'(res_valid), 64'd0);
    check_eq("abort_count",    64'(res_count), 64'd0);
    check_eq("abort_any",      64'(res_any), 64'd0);
    rv_seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (res_valid || det_enable) rv_seen = 1'b1;
      tick();
    end
    check_eq("abort_no_result", 64'(rv_seen), 64'd0);

    // Async reset at SHIFT idx 8
    in_valid = 1'b1; in_data = 16'h5555;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    check_eq("rst_mid_pre_enable", 64'(det_enable), 64'd1);
    rstb = 1'b0;
    #1;
    check_eq("rst_mid_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_mid_enable",   64'(det_enable), 64'd0);
    check_eq("rst_mid_serial",   64'(det_serial), 64'd0);
    check_eq("rst_mid_valid",    64'(res_valid), 64'd0);
    check_eq("rst_mid_count",    64'(res_count), 64'd0);
    tick();
    rstb = 1'b1;
    tick();
    check_eq("rst_mid_ready_after", 64'(in_ready), 64'd1);
    check_eq("rst_mid_no_result",   64'(res_valid), 64'd0);

    scan(16'h6000, lat, c, a, f);
    check_eq("recover_latency", 64'(lat), 64'(WORD_W + 1));
    check_eq("recover_count", c, 64'd2);
    check_eq("recover_first", f, 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
